// File: rtl/proc_dmem_subword_unit.sv
// proc_dmem_subword_unit
//   Sits between a processor load/store port and a word-wide data memory.
//   Turns byte/half/word requests into aligned word requests with byte
//   write enables, and turns aligned word responses back into sign- or
//   zero-extended load results. Misaligned requests never reach memory;
//   they get an in-order zero response and raise a sticky error flag.
//   An in-order queue of request descriptors keeps responses matched to
//   requests, including the locally generated ones.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   preq_*               processor request (val/rdy, type, size, unsigned, addr, data)
//   mreq_*               memory request (val/rdy, type, word addr, data, byte wmask)
//   mresp_*              memory response (val/rdy, aligned word data)
//   presp_*              processor response (val/rdy, formatted data)
//   misalign_err         sticky flag, set by any accepted misaligned request
//   num_outstanding      number of tracked, not yet answered requests
module proc_dmem_subword_unit #(
  parameter int p_num_entries = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               preq_val,
  output logic                               preq_rdy,
  input  logic                               preq_type,
  input  logic [1:0]                         preq_size,
  input  logic                               preq_unsigned,
  input  logic [31:0]                        preq_addr,
  input  logic [31:0]                        preq_data,
  output logic                               mreq_val,
  input  logic                               mreq_rdy,
  output logic                               mreq_type,
  output logic [31:0]                        mreq_addr,
  output logic [31:0]                        mreq_data,
  output logic [3:0]                         mreq_wmask,
  input  logic                               mresp_val,
  output logic                               mresp_rdy,
  input  logic [31:0]                        mresp_data,
  output logic                               presp_val,
  input  logic                               presp_rdy,
  output logic [31:0]                        presp_data,
  output logic                               misalign_err,
  output logic [$clog2(p_num_entries):0]     num_outstanding
);

  localparam int PW = $clog2(p_num_entries);
  localparam int CW = PW + 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  // One descriptor per accepted request; bypass marks a locally answered one.
  typedef struct packed {
    logic       req_type;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       bypass;
  } entry_t;

  entry_t          queue_r [p_num_entries];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            err_r;

  logic [1:0]      off_s;
  logic            misaligned_s;
  logic            full_s;
  logic            empty_s;
  logic            enq_s;
  logic            deq_s;
  entry_t          head_s;
  entry_t          new_entry_s;

  // Right-justify the addressed bytes of a memory word and extend them.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic [1:0]  off,
                                           input logic        uns);
    logic [31:0] w;
    logic        s;
    w = word >> {off, 3'b000};
    s = ~uns;
    case (size)
      SZ_BYTE: fmt_load = {{24{s & w[7]}}, w[7:0]};
      SZ_HALF: fmt_load = {{16{s & w[15]}}, w[15:0]};
      default: fmt_load = word;
    endcase
  endfunction

  assign off_s     = preq_addr[1:0];
  assign full_s    = (count_r == CW'(p_num_entries));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign head_s    = queue_r[head_r];
  assign mreq_type = preq_type;
  assign mreq_addr = {preq_addr[31:2], 2'b00};

  // Alignment check; size 3 behaves as a word.
  always_comb begin
    misaligned_s = 1'b0;
    case (preq_size)
      SZ_BYTE: misaligned_s = 1'b0;
      SZ_HALF: misaligned_s = off_s[0];
      default: misaligned_s = (off_s != 2'b00);
    endcase
  end

  // Store data replication and byte enables for the memory word.
  always_comb begin
    mreq_data  = preq_data;
    mreq_wmask = 4'b0000;
    case (preq_size)
      SZ_BYTE: begin
        mreq_data  = {4{preq_data[7:0]}};
        mreq_wmask = 4'b0001 << off_s;
      end
      SZ_HALF: begin
        mreq_data  = {2{preq_data[15:0]}};
        mreq_wmask = 4'b0011 << off_s;
      end
      default: begin
        mreq_data  = preq_data;
        mreq_wmask = 4'b1111;
      end
    endcase
    if (!preq_type) begin
      mreq_wmask = 4'b0000;
    end else begin
      mreq_wmask = mreq_wmask;
    end
  end

  // Request-side handshake; misaligned requests are accepted without memory.
  always_comb begin
    preq_rdy = 1'b0;
    mreq_val = 1'b0;
    if (reset) begin
      preq_rdy = 1'b0;
      mreq_val = 1'b0;
    end else if (misaligned_s) begin
      preq_rdy = ~full_s;
      mreq_val = 1'b0;
    end else begin
      preq_rdy = mreq_rdy & ~full_s;
      mreq_val = preq_val & ~full_s;
    end
  end

  // Response-side steering driven by the queue head.
  always_comb begin
    presp_val  = 1'b0;
    mresp_rdy  = 1'b0;
    presp_data = 32'h0000_0000;
    if (reset || empty_s) begin
      presp_val = 1'b0;
      mresp_rdy = 1'b0;
    end else if (head_s.bypass) begin
      presp_val = 1'b1;
      mresp_rdy = 1'b0;
    end else begin
      presp_val = mresp_val;
      mresp_rdy = presp_rdy;
      if (!head_s.req_type) begin
        presp_data = fmt_load(mresp_data, head_s.size, head_s.off, head_s.uns);
      end else begin
        presp_data = 32'h0000_0000;
      end
    end
  end

  assign enq_s = preq_val & preq_rdy;
  assign deq_s = presp_val & presp_rdy;

  assign new_entry_s = '{req_type: preq_type, size: preq_size, uns: preq_unsigned,
                         off: off_s, bypass: misaligned_s};

  // Queue storage, pointers, occupancy and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        queue_r[i] <= '0;
      end
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (enq_s) begin
        queue_r[tail_r] <= new_entry_s;
        tail_r          <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (enq_s && misaligned_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign misalign_err    = err_r;
  assign num_outstanding = count_r;

endmodule

// File: doc/proc_dmem_subword_unit.md
PROC_DMEM_SUBWORD_UNIT -- requirements
Module: proc_DmemSubwordUnit

Interface
REQ-001 SHALL have parameter p_num_entries, default 2: depth of the outstanding-request tracking queue (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports preq_val/preq_rdy  input/output  1/1  processor-side request handshake.
REQ-005 SHALL have ports preq_type  input  1  0=load, 1=store; preq_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word); preq_unsigned  input  1  zero-extend load.
REQ-006 SHALL have ports preq_addr  input  32  byte address; preq_data  input  32  store data, right-justified.
REQ-007 SHALL have ports mreq_val/mreq_rdy  output/input  1/1; mreq_type  output  1; mreq_addr  output  32  {preq_addr[31:2],2'b00}; mreq_data  output  32; mreq_wmask  output  4  byte write enables.
REQ-008 SHALL have ports mresp_val/mresp_rdy  input/output  1/1; mresp_data  input  32  aligned word.
REQ-009 SHALL have ports presp_val/presp_rdy  output/input  1/1; presp_data  output  32  formatted load result.
REQ-010 SHALL have ports misalign_err  output  1  sticky error flag; num_outstanding  output  $clog2(p_num_entries)+1  tracked entry count.

Function
REQ-011 SHALL, per request, compute off=preq_addr[1:0]; misaligned = (half and off[0]=1) or (word and off!=0).
REQ-012 SHALL, for aligned requests, drive mreq_val = preq_val & !full; preq_rdy = mreq_rdy & !full; transfer when preq_val & preq_rdy.
REQ-013 SHALL, for misaligned requests, drive mreq_val=0, preq_rdy=!full; on transfer enqueue a bypass entry and set misalign_err on the next edge.
REQ-014 SHALL generate mreq_wmask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111; loads 4'b0000.
REQ-015 SHALL generate mreq_data: byte {4{preq_data[7:0]}}; half {2{preq_data[15:0]}}; word preq_data.
REQ-016 SHALL enqueue, per transferred request, entry {type,size,unsigned,off,bypass} into an in-order circular queue (wrap-around pointers, counter); full = count==p_num_entries.
REQ-017 SHALL not enqueue when full, even if head dequeues the same cycle (no full-bypass).
REQ-018 SHALL, when head is non-bypass, drive presp_val = mresp_val, mresp_rdy = presp_rdy (zero-cycle combinational pass-through).
REQ-019 SHALL, when head is bypass, drive presp_val=1, presp_data=0, mresp_rdy=0.
REQ-020 SHALL drive presp_val=0 and mresp_rdy=0 when queue empty; stray mresp is never consumed.
REQ-021 SHALL dequeue the head on presp_val & presp_rdy; enqueue and dequeue in the same cycle leave count unchanged.
REQ-022 SHALL format load data: w = mresp_data >> (8*off); byte {24{s&w[7]},w[7:0]}, half {16{s&w[15]},w[15:0]}, word mresp_data, where s = !unsigned.
REQ-023 SHALL return presp_data=0 for store responses.
REQ-024 SHALL hold misalign_err at 1 until reset.
REQ-025 SHALL keep responses strictly in request order including bypass entries.

Reset
REQ-026 SHALL, on reset, clear count and pointers, misalign_err=0, num_outstanding=0; presp_val=0, mresp_rdy=0, mreq_val=0 during reset.
REQ-027 SHALL, on reset mid-operation, discard all outstanding entries; late memory responses after reset are ignored (mresp_rdy=0 while empty).

Verification
REQ-028 SHALL cover: lb addr 0x1003, mresp_data 0x80FF_1234 -> mreq_addr 0x1000, presp_data 0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-029 SHALL cover: sh addr 0x2002 data 0xABCD_BEEF -> mreq_wmask 4'b1100, mreq_data 0xBEEF_BEEF, presp_data 0.
REQ-030 SHALL cover: lw addr 0x3001 -> no mreq, presp_data 0, misalign_err=1 next cycle, stays 1.
REQ-031 SHALL cover: 3 back-to-back loads with mreq_rdy=1, mresp_val=0 (depth 2) -> third held, preq_rdy=0, num_outstanding=2.
REQ-032 SHALL cover: aligned load followed by misaligned load -> bypass response appears only after first response dequeued.
REQ-033 SHALL cover: random presp_rdy/mreq_rdy/mresp_val backpressure 1000 ops vs reference model, plus reset asserted with 2 outstanding -> num_outstanding=0, no presp.
